// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter
//   Round-robin arbiter and sequencer for a single shared WIDTH-bit
//   parallel-in/parallel-out register (the "pipo"). One requester word is
//   accepted at a time. The pipo is then walked through a load cycle and a
//   transfer cycle, and the word is presented until the consumer acknowledges.
//
// Ports
//   clk         rising-edge clock, shared with the pipo
//   reset       asynchronous, active-low reset
//   req         per-requester level request, held until its gnt is seen
//   req_data    requester i word at [i*WIDTH +: WIDTH]
//   gnt         one-hot pulse in the cycle after the winning request is captured
//   pipo_reset  active-high synchronous reset to the pipo (one edge after reset)
//   pipo_load   pipo load pin
//   pipo_din    pipo data_in pins
//   out_valid   pipo data_out holds the word owned by out_id
//   out_id      owner of the word currently on pipo data_out
//   out_ack     consumer took the word; only looked at while out_valid=1
//
// All outputs come straight from flops.
module pipo_load_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   pipo_reset,
  output logic                   pipo_load,
  output logic [WIDTH-1:0]       pipo_din,
  output logic                   out_valid,
  output logic [IDW-1:0]         out_id,
  input  logic                   out_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Round-robin search starting at ptr; returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] r,
                                           input logic [IDW-1:0]   ptr);
    logic           found;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    idx   = {IDW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  state_t             state_r, state_s;
  logic [N_REQ-1:0]   gnt_r, gnt_s;
  logic               pipo_reset_r;
  logic               load_r, load_s;
  logic [WIDTH-1:0]   din_r, din_s;
  logic               valid_r, valid_s;
  logic [IDW-1:0]     id_r, id_s;
  logic [IDW-1:0]     rr_r, rr_s;
  logic [IDW:0]       pick_s;
  logic               pick_found_s;
  logic [IDW-1:0]     pick_idx_s;
  logic [IDW-1:0]     rr_after_s;

  assign pick_s       = rr_pick(req, rr_r);
  assign pick_found_s = pick_s[IDW];
  assign pick_idx_s   = pick_s[IDW-1:0];

  // Pointer moves to the requester just after the one being retired, wrapping.
  assign rr_after_s = (id_r == IDW'(N_REQ - 1)) ? {IDW{1'b0}} : (id_r + {{(IDW-1){1'b0}}, 1'b1});

  // Next-state and next-output logic for the load/transfer sequence.
  always_comb begin
    state_s = state_r;
    gnt_s   = {N_REQ{1'b0}};
    load_s  = 1'b0;
    din_s   = din_r;
    valid_s = valid_r;
    id_s    = id_r;
    rr_s    = rr_r;
    case (state_r)
      ST_IDLE: begin
        // Requests are not looked at while the pipo is still being reset.
        if (!pipo_reset_r && pick_found_s) begin
          state_s = ST_LOAD;
          gnt_s   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          load_s  = 1'b1;
          din_s   = req_data[int'(pick_idx_s)*WIDTH +: WIDTH];
          id_s    = pick_idx_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // pipo captures pipo_din into its holding stage on this edge.
        state_s = ST_XFER;
      end
      ST_XFER: begin
        // pipo moves the held word to data_out on this edge.
        valid_s = 1'b1;
        state_s = ST_OUT;
      end
      ST_OUT: begin
        // load stays low, so the pipo keeps re-copying the same word.
        if (out_ack) begin
          valid_s = 1'b0;
          rr_s    = rr_after_s;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      gnt_r        <= {N_REQ{1'b0}};
      pipo_reset_r <= 1'b1;
      load_r       <= 1'b0;
      din_r        <= {WIDTH{1'b0}};
      valid_r      <= 1'b0;
      id_r         <= {IDW{1'b0}};
      rr_r         <= {IDW{1'b0}};
    end else begin
      state_r      <= state_s;
      gnt_r        <= gnt_s;
      pipo_reset_r <= 1'b0;
      load_r       <= load_s;
      din_r        <= din_s;
      valid_r      <= valid_s;
      id_r         <= id_s;
      rr_r         <= rr_s;
    end
  end

  assign gnt        = gnt_r;
  assign pipo_reset = pipo_reset_r;
  assign pipo_load  = load_r;
  assign pipo_din   = din_r;
  assign out_valid  = valid_r;
  assign out_id     = id_r;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter with a small behavioural pipo attached.
module tb_pipo_load_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt;
  logic                   pipo_reset;
  logic                   pipo_load;
  logic [WIDTH-1:0]       pipo_din;
  logic                   out_valid;
  logic [IDW-1:0]         out_id;
  logic                   out_ack;

  // Behavioural pipo: load captures into tmp, load=0 copies tmp to data_out.
  logic [WIDTH-1:0] pipo_tmp;
  logic [WIDTH-1:0] pipo_dout;

  int errors = 0;
  int checks = 0;

  pipo_load_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .pipo_reset (pipo_reset),
    .pipo_load  (pipo_load),
    .pipo_din   (pipo_din),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_ack    (out_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pipo_reset) begin
      pipo_tmp  <= 4'h0;
      pipo_dout <= 4'h0;
    end else if (pipo_load) begin
      pipo_tmp  <= pipo_din;
    end else begin
      pipo_dout <= pipo_tmp;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset state, req ignored while pipo_reset is high
    reset    = 1'b0;
    req      = 4'b0001;
    req_data = {4'h0, 4'h0, 4'h0, 4'b0010};
    out_ack  = 1'b0;
    #10;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_load", pipo_load, 1'b0);
    check("rst_din", pipo_din, 4'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_id", out_id, 2'd0);
    check("rst_pipo_reset", pipo_reset, 1'b1);
    reset = 1'b1;
    tick();
    check("rel_pipo_reset", pipo_reset, 1'b0);
    check("rel_req_ignored", gnt, 4'b0000);
    check("rel_load", pipo_load, 1'b0);
    out_ack = 1'b1;

    // 2. single requester
    tick();
    check("t2_gnt", gnt, 4'b0001);
    check("t2_load", pipo_load, 1'b1);
    check("t2_din", pipo_din, 4'b0010);
    check("t2_id", out_id, 2'd0);
    tick();
    check("t2_gnt_pulse", gnt, 4'b0000);
    check("t2_load_off", pipo_load, 1'b0);
    check("t2_valid_early", out_valid, 1'b0);
    tick();
    check("t2_valid", out_valid, 1'b1);
    check("t2_out_id", out_id, 2'd0);
    check("t2_dout", pipo_dout, 4'b0010);
    req = 4'b0000;
    tick();
    check("t2_valid_drop", out_valid, 1'b0);

    // re-reset so the pointer starts at 0 again
    reset    = 1'b0;
    req      = 4'b1111;
    req_data = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    check("rr_rst_pipo_reset", pipo_reset, 1'b1);
    #3;
    reset = 1'b1;
    tick();
    check("rr_rel_no_gnt", gnt, 4'b0000);

    // 3. all requesting: 0,1,2,3 then wrap, one word per 4 cycles
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t3_gnt", gnt, 32'(4'b0001 << (k % 4)));
      check("t3_id", out_id, 32'(k % 4));
      check("t3_din", pipo_din, 32'((k % 4) + 1));
      tick();
      check("t3_gnt_off", gnt, 4'b0000);
      tick();
      check("t3_valid", out_valid, 1'b1);
      check("t3_dout", pipo_dout, 32'((k % 4) + 1));
      tick();
      check("t3_ack", out_valid, 1'b0);
    end

    // 4. held ack: output stable, then next grant goes to requester 2
    req     = 4'b0101;
    out_ack = 1'b0;
    tick();
    check("t4_gnt0", gnt, 4'b0001);
    tick();
    tick();
    check("t4_valid", out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_dout", pipo_dout, 4'd1);
      check("t4_hold_id", out_id, 2'd0);
      check("t4_hold_gnt", gnt, 4'b0000);
    end
    out_ack = 1'b1;
    tick();
    check("t4_ack", out_valid, 1'b0);
    tick();
    check("t4_gnt2", gnt, 4'b0100);
    check("t4_id2", out_id, 2'd2);
    check("t4_din2", pipo_din, 4'd3);
    tick();
    tick();
    check("t4_dout2", pipo_dout, 4'd3);
    tick();

    // 5. requester 1 withdraws and changes data right after its grant
    req      = 4'b0010;
    req_data = {4'd4, 4'd3, 4'hA, 4'd1};
    tick();
    check("t5_gnt", gnt, 4'b0010);
    check("t5_din", pipo_din, 4'hA);
    req      = 4'b0000;
    req_data = {4'd4, 4'd3, 4'h5, 4'd1};
    tick();
    check("t5_gnt_off", gnt, 4'b0000);
    tick();
    check("t5_valid", out_valid, 1'b1);
    check("t5_id", out_id, 2'd1);
    check("t5_dout", pipo_dout, 4'hA);
    tick();
    check("t5_ack", out_valid, 1'b0);
    tick();
    check("t5_no_gnt", gnt, 4'b0000);
    check("t5_no_load", pipo_load, 1'b0);

    // 6. reset during XFER aborts; first grant afterwards starts at 0
    req = 4'b1000;
    tick();
    check("t6_gnt3", gnt, 4'b1000);
    tick();
    reset = 1'b0;
    #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_gnt", gnt, 4'b0000);
    check("t6_load", pipo_load, 1'b0);
    check("t6_pipo_reset", pipo_reset, 1'b1);
    req = 4'b1111;
    #3;
    reset = 1'b1;
    tick();
    check("t6_rel_pipo_reset", pipo_reset, 1'b0);
    check("t6_rel_gnt", gnt, 4'b0000);
    check("t6_rel_valid", out_valid, 1'b0);
    tick();
    check("t6_first_gnt", gnt, 4'b0001);
    check("t6_first_id", out_id, 2'd0);
    check("t6_first_din", pipo_din, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
